// File: rtl/cr_prefix_fe_ctl_pkg.sv
// -----------------------------------------------------------------------------
// cr_prefix_fe_ctl_pkg
//   Shared types and default geometry for the prefix feature-extraction
//   front-end sequencer (cr_prefix_fe_ctl).
//
//   - fe_ctl_state_e      : sequencer state encoding (6 states, 3 bits)
//   - FE_CTL_*            : default beat width / block geometry / settle time
//   - FE_CTL_BEATS_PER_BLK: data beats that make up one array block
//   - FE_CTL_MAX_BEATS    : frame capacity in beats (N_BLKS blocks)
// -----------------------------------------------------------------------------
package cr_prefix_fe_ctl_pkg;

  localparam int FE_CTL_DWIDTH        = 64;
  localparam int FE_CTL_BLK_BYTES     = 64;
  localparam int FE_CTL_N_BLKS        = 4;
  localparam int FE_CTL_SETTLE        = 2;
  localparam int FE_CTL_BEATS_PER_BLK = FE_CTL_BLK_BYTES * 8 / FE_CTL_DWIDTH;
  localparam int FE_CTL_MAX_BEATS     = FE_CTL_N_BLKS * FE_CTL_BEATS_PER_BLK;

  typedef enum logic [2:0] {
    FE_IDLE   = 3'd0,
    FE_RELOAD = 3'd1,
    FE_STREAM = 3'd2,
    FE_SKIP   = 3'd3,
    FE_SETTLE = 3'd4,
    FE_HOLD   = 3'd5
  } fe_ctl_state_e;

endpackage

// File: rtl/cr_prefix_fe_ctl.sv
// -----------------------------------------------------------------------------
// cr_prefix_fe_ctl
//   Sequencer in front of the prefix feature-extraction array. Takes one
//   frame per request from an AXI-stream source, replays its beats onto the
//   array's character bus (one cycle later), caps the frame at
//   N_BLKS*BLK_BYTES bytes, lets the array counters settle and then offers a
//   result handshake to the feature consumer.
//
//   Ports
//     clk, rst             : clock, synchronous active-high reset
//     in_tvalid/in_tready  : source beat handshake
//     in_tdata/in_tstrb    : source beat data and byte strobes
//     in_tlast             : last beat of the frame
//     ibc_data_tlv_tdata   : character data to the array
//     ibc_data_vbytes      : valid-byte mask to the array (0 = no character)
//     ibc_blk_sel          : block select to the array
//     ibc_ctr_reload       : one-cycle counter reload pulse
//     result_valid         : counters final for the current frame
//     result_ack           : consumer has sampled the counters
//     result_trunc         : frame exceeded capacity (qualified by result_valid)
//     busy                 : sequencer not idle
//
//   Handshake semantics: a source beat transfers on a rising edge where
//   in_tvalid and in_tready are both high. in_tready is a registered decode of
//   the state only, so it never depends combinationally on in_tvalid. The
//   result transfers on a rising edge where result_valid and result_ack are
//   both high; result_ack is ignored whenever result_valid is low.
//
//   All outputs are registered.
// -----------------------------------------------------------------------------
module cr_prefix_fe_ctl
  import cr_prefix_fe_ctl_pkg::*;
#(
  parameter int DWIDTH    = FE_CTL_DWIDTH,
  parameter int BLK_BYTES = FE_CTL_BLK_BYTES,
  parameter int N_BLKS    = FE_CTL_N_BLKS,
  parameter int SETTLE    = FE_CTL_SETTLE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_tvalid,
  output logic                       in_tready,
  input  logic [DWIDTH-1:0]          in_tdata,
  input  logic [DWIDTH/8-1:0]        in_tstrb,
  input  logic                       in_tlast,
  output logic [DWIDTH-1:0]          ibc_data_tlv_tdata,
  output logic [DWIDTH/8-1:0]        ibc_data_vbytes,
  output logic [$clog2(N_BLKS)-1:0]  ibc_blk_sel,
  output logic                       ibc_ctr_reload,
  output logic                       result_valid,
  input  logic                       result_ack,
  output logic                       result_trunc,
  output logic                       busy
);

  localparam int STRB_W        = DWIDTH / 8;
  localparam int BEATS_PER_BLK = BLK_BYTES * 8 / DWIDTH;
  localparam int MAX_BEATS     = N_BLKS * BEATS_PER_BLK;
  localparam int BSEL_W        = $clog2(N_BLKS);
  // Wide enough to hold MAX_BEATS itself, so the count never wraps.
  localparam int CNT_W         = $clog2(MAX_BEATS + 1);
  localparam int SETTLE_W      = $clog2(SETTLE + 1);

  fe_ctl_state_e       state_q, state_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic                trunc_q, trunc_d;

  logic [DWIDTH-1:0]   tdata_q, tdata_d;
  logic [STRB_W-1:0]   vbytes_q, vbytes_d;
  logic [BSEL_W-1:0]   blk_sel_q, blk_sel_d;
  logic                reload_q, reload_d;
  logic                tready_q, tready_d;
  logic                rvalid_q, rvalid_d;
  logic                rtrunc_q, rtrunc_d;
  logic                busy_q, busy_d;

  logic                accept;

  assign accept = in_tvalid & tready_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    settle_cnt_d = settle_cnt_q;
    trunc_d      = trunc_q;
    tdata_d      = tdata_q;
    vbytes_d     = '0;
    blk_sel_d    = blk_sel_q;

    case (state_q)
      FE_IDLE: begin
        if (in_tvalid) state_d = FE_RELOAD;
      end

      FE_RELOAD: begin
        beat_cnt_d = '0;
        trunc_d    = 1'b0;
        state_d    = FE_STREAM;
      end

      FE_STREAM: begin
        if (accept) begin
          // Zero-strobe beats still count and are replayed with vbytes=0.
          tdata_d    = in_tdata;
          vbytes_d   = in_tstrb;
          blk_sel_d  = BSEL_W'(beat_cnt_q / CNT_W'(BEATS_PER_BLK));
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (in_tlast) begin
            // tlast wins over the capacity check: a frame that exactly
            // fills capacity is not truncated.
            state_d      = FE_SETTLE;
            settle_cnt_d = '0;
          end else if (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) begin
            state_d = FE_SKIP;
            trunc_d = 1'b1;
          end
        end
      end

      FE_SKIP: begin
        // Over-capacity beats are drained without touching the array.
        if (accept && in_tlast) begin
          state_d      = FE_SETTLE;
          settle_cnt_d = '0;
        end
      end

      FE_SETTLE: begin
        // The first SETTLE cycle coincides with the final character drive,
        // so result_valid appears SETTLE+1 cycles after that drive.
        if (settle_cnt_q == SETTLE_W'(SETTLE)) begin
          state_d = FE_HOLD;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end
      end

      FE_HOLD: begin
        if (result_ack) state_d = FE_IDLE;
      end

      default: begin
        state_d = FE_IDLE;
      end
    endcase

    // Registered outputs are decoded from the next state so they line up
    // with the state they describe.
    reload_d = (state_d == FE_RELOAD);
    tready_d = (state_d == FE_STREAM) || (state_d == FE_SKIP);
    rvalid_d = (state_d == FE_HOLD);
    rtrunc_d = (state_d == FE_HOLD) && trunc_d;
    busy_d   = (state_d != FE_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FE_IDLE;
      beat_cnt_q   <= '0;
      settle_cnt_q <= '0;
      trunc_q      <= 1'b0;
      tdata_q      <= '0;
      vbytes_q     <= '0;
      blk_sel_q    <= '0;
      reload_q     <= 1'b0;
      tready_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rtrunc_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      trunc_q      <= trunc_d;
      tdata_q      <= tdata_d;
      vbytes_q     <= vbytes_d;
      blk_sel_q    <= blk_sel_d;
      reload_q     <= reload_d;
      tready_q     <= tready_d;
      rvalid_q     <= rvalid_d;
      rtrunc_q     <= rtrunc_d;
      busy_q       <= busy_d;
    end
  end

  assign in_tready          = tready_q;
  assign ibc_data_tlv_tdata = tdata_q;
  assign ibc_data_vbytes    = vbytes_q;
  assign ibc_blk_sel        = blk_sel_q;
  assign ibc_ctr_reload     = reload_q;
  assign result_valid       = rvalid_q;
  assign result_trunc       = rtrunc_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_cr_prefix_fe_ctl.sv
// -----------------------------------------------------------------------------
// tb_cr_prefix_fe_ctl
//   Self-checking bench for cr_prefix_fe_ctl. Each frame is described as a
//   list of beats; the expected per-cycle output timeline is derived from
//   that list and the cycle on which each beat was offered: reload one cycle
//   after the request, tready from the next cycle, every accepted beat
//   visible one cycle later (only the first 32), result 3 cycles after the
//   tlast beat's drive cycle, and trunc when the frame is longer than 32
//   beats. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cr_prefix_fe_ctl;

  localparam int DW   = 64;
  localparam int SW   = DW / 8;
  localparam int BPB  = 8;   // beats per block
  localparam int MAXB = 32;  // frame capacity in beats

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst;
  logic          in_tvalid;
  logic          in_tready;
  logic [DW-1:0] in_tdata;
  logic [SW-1:0] in_tstrb;
  logic          in_tlast;
  logic [DW-1:0] ibc_data_tlv_tdata;
  logic [SW-1:0] ibc_data_vbytes;
  logic [1:0]    ibc_blk_sel;
  logic          ibc_ctr_reload;
  logic          result_valid;
  logic          result_ack;
  logic          result_trunc;
  logic          busy;

  always #5 clk = ~clk;

  cr_prefix_fe_ctl dut (
    .clk                (clk),
    .rst                (rst),
    .in_tvalid          (in_tvalid),
    .in_tready          (in_tready),
    .in_tdata           (in_tdata),
    .in_tstrb           (in_tstrb),
    .in_tlast           (in_tlast),
    .ibc_data_tlv_tdata (ibc_data_tlv_tdata),
    .ibc_data_vbytes    (ibc_data_vbytes),
    .ibc_blk_sel        (ibc_blk_sel),
    .ibc_ctr_reload     (ibc_ctr_reload),
    .result_valid       (result_valid),
    .result_ack         (result_ack),
    .result_trunc       (result_trunc),
    .busy               (busy)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;

  // Character bus values that hold between accepted beats.
  logic [DW-1:0] last_tdata;
  logic [1:0]    last_blk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic tready, input logic reload,
                            input logic [SW-1:0] vb, input logic [1:0] blk,
                            input logic [DW-1:0] tdata, input logic rvalid,
                            input logic rtrunc, input logic bsy);
    check_val({tag, ".tready"}, 64'(in_tready),       64'(tready));
    check_val({tag, ".reload"}, 64'(ibc_ctr_reload),  64'(reload));
    check_val({tag, ".vbytes"}, 64'(ibc_data_vbytes), 64'(vb));
    check_val({tag, ".blk_sel"}, 64'(ibc_blk_sel),    64'(blk));
    check_val({tag, ".tdata"},  ibc_data_tlv_tdata,   tdata);
    check_val({tag, ".rvalid"}, 64'(result_valid),    64'(rvalid));
    check_val({tag, ".rtrunc"}, 64'(result_trunc),    64'(rtrunc));
    check_val({tag, ".busy"},   64'(busy),            64'(bsy));
  endtask

  task automatic expect_idle(input string tag);
    expect_cyc(tag, 1'b0, 1'b0, '0, last_blk, last_tdata, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------- driver
  // nbeats    : beats in the frame (tlast on the final one)
  // stall_pct : chance per cycle of withholding tvalid while streaming
  // alt       : tvalid toggles 1,0,1,0 while streaming instead
  // ack_dly   : cycles result_valid is left unacknowledged
  // rst_beat  : if nonzero, pulse rst once this many beats were accepted
  // hold_tv   : keep tvalid high through settle/hold
  // last_strb : strobe of the final beat (0 = random low-justified mask)
  task automatic run_frame(input int nbeats, input int stall_pct, input bit alt,
                           input int ack_dly, input int rst_beat, input bit hold_tv,
                           input logic [SW-1:0] last_strb);
    logic [DW-1:0] d[$];
    logic [SW-1:0] s[$];
    logic [SW-1:0] evb;
    bit            tv;
    bit            acc_prev;
    bit            trunc;
    int            acc;
    int            kprev;
    int            cyc;

    for (int k = 0; k < nbeats; k++) begin
      d.push_back({$urandom, $urandom});
      if (k == nbeats - 1)
        s.push_back((last_strb != '0) ? last_strb : (8'hFF >> $urandom_range(0, 7)));
      else
        s.push_back(($urandom_range(0, 9) == 0) ? 8'h00 : 8'hFF);
    end

    // Request: the first beat is presented while the sequencer is idle.
    expect_idle("idle");
    in_tvalid = 1'b1;
    in_tdata  = d[0];
    in_tstrb  = s[0];
    in_tlast  = (nbeats == 1);
    @(negedge clk);
    expect_cyc("reload", 1'b0, 1'b1, '0, last_blk, last_tdata, 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    acc      = 0;
    kprev    = 0;
    acc_prev = 1'b0;
    cyc      = 0;
    while (1) begin
      evb = '0;
      if (acc_prev && kprev < MAXB) begin
        last_tdata = d[kprev];
        last_blk   = 2'(kprev / BPB);
        evb        = s[kprev];
      end
      expect_cyc("stream", 1'b1, 1'b0, evb, last_blk, last_tdata, 1'b0, 1'b0, 1'b1);

      if (rst_beat > 0 && acc == rst_beat) begin
        rst       = 1'b1;
        in_tvalid = 1'b0;
        @(negedge clk);
        last_tdata = '0;
        last_blk   = '0;
        expect_idle("rst");
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          expect_idle("post_rst");
        end
        return;
      end

      if (alt) tv = (cyc % 2 == 0);
      else     tv = ($urandom_range(0, 99) >= stall_pct) || (cyc > 4 * nbeats + 40);
      in_tvalid = tv;
      if (tv) begin
        in_tdata = d[acc];
        in_tstrb = s[acc];
        in_tlast = (acc == nbeats - 1);
      end else begin
        in_tdata = {$urandom, $urandom};
        in_tstrb = 8'($urandom);
        in_tlast = 1'($urandom);
      end
      acc_prev = tv;
      kprev    = acc;
      if (tv) acc++;
      cyc++;
      @(negedge clk);
      if (tv && kprev == nbeats - 1) break;
    end

    // Drive cycle of the tlast beat (nothing new if it was over capacity).
    trunc = (nbeats > MAXB);
    evb   = '0;
    if (kprev < MAXB) begin
      last_tdata = d[kprev];
      last_blk   = 2'(kprev / BPB);
      evb        = s[kprev];
    end
    expect_cyc("last_drv", 1'b0, 1'b0, evb, last_blk, last_tdata, 1'b0, 1'b0, 1'b1);
    in_tvalid = hold_tv;
    in_tlast  = 1'b0;
    in_tdata  = {$urandom, $urandom};

    repeat (2) begin
      @(negedge clk);
      expect_cyc("settle", 1'b0, 1'b0, '0, last_blk, last_tdata, 1'b0, 1'b0, 1'b1);
    end

    for (int h = 0; h <= ack_dly; h++) begin
      @(negedge clk);
      expect_cyc("hold", 1'b0, 1'b0, '0, last_blk, last_tdata, 1'b1, trunc, 1'b1);
      result_ack = (h == ack_dly);
    end
    @(negedge clk);
    result_ack = 1'b0;
    in_tvalid  = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      expect_idle("gap");
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst        = 1'b1;
    in_tvalid  = 1'b0;
    in_tdata   = '0;
    in_tstrb   = '0;
    in_tlast   = 1'b0;
    result_ack = 1'b0;
    last_tdata = '0;
    last_blk   = '0;

    @(negedge clk);
    @(negedge clk);
    expect_idle("reset");
    rst = 1'b0;
    // Acks while idle must be ignored.
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    expect_idle("stray_ack");

    run_frame(10, 0, 1'b0, 0, 0, 1'b0, 8'h0F);   // basic frame, two blocks
    idle_gap(2);
    run_frame(40, 0, 1'b0, 1, 0, 1'b0, 8'h00);   // truncated frame
    idle_gap(1);
    run_frame(32, 0, 1'b0, 0, 0, 1'b0, 8'h00);   // exactly fills capacity
    run_frame(16, 0, 1'b1, 2, 0, 1'b0, 8'h00);   // alternating source stalls
    run_frame(12, 20, 1'b0, 20, 0, 1'b1, 8'h00); // long ack wait, tvalid held
    run_frame(9, 0, 1'b0, 0, 5, 1'b0, 8'h00);    // reset after beat 5
    run_frame(6, 0, 1'b0, 0, 0, 1'b0, 8'h00);    // fresh frame after reset
    run_frame(1, 0, 1'b0, 0, 0, 1'b0, 8'h00);    // single-beat frame

    repeat (25) begin
      idle_gap($urandom_range(0, 3));
      run_frame($urandom_range(1, 45), $urandom_range(0, 50), 1'b0,
                $urandom_range(0, 4), 0, 1'($urandom_range(0, 1)), 8'h00);
    end
    idle_gap(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

endmodule
